// File: rtl/mastermind_engine.sv
// Mastermind game engine: loads a secret code and guesses one peg per key press.
// Each guess is scored by exact and colour-partial counts, then a win or loss is declared.
module mastermind_engine #(
   parameter  int PEGS        = 4,
   parameter  int COLOR_BITS  = 3,
   parameter  int MAX_GUESSES = 8,
   localparam int NCOLORS     = 1 << COLOR_BITS,
   localparam int CW          = $clog2(PEGS + 1),
   localparam int GW          = $clog2(MAX_GUESSES + 1),
   localparam int IW          = (PEGS > 1) ? $clog2(PEGS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [COLOR_BITS-1:0] peg_in,
   input  logic                  new_game,
   output logic [1:0]            phase,
   output logic [IW-1:0]         peg_index,
   output logic [GW-1:0]         guess_count,
   output logic [CW-1:0]         exact_count,
   output logic [CW-1:0]         partial_count,
   output logic                  score_valid,
   output logic                  win,
   output logic                  lose
);

   typedef enum logic [2:0] {
      S_LOAD, S_LOAD_WAIT, S_GUESS, S_GUESS_WAIT, S_SCORE, S_DONE
   } state_t;

   localparam logic [IW-1:0]       I_LAST = IW'(PEGS - 1);
   localparam logic [GW-1:0]       G_MAX  = GW'(MAX_GUESSES);
   localparam logic [CW-1:0]       C_FULL = CW'(PEGS);
   localparam logic [COLOR_BITS:0] C_END  = (COLOR_BITS + 1)'(NCOLORS);

   state_t r_state;
   state_t w_next;

   logic [PEGS-1:0][COLOR_BITS-1:0] r_code;
   logic [PEGS-1:0][COLOR_BITS-1:0] r_guess;
   logic [IW-1:0]       r_idx;
   logic [GW-1:0]       r_gc;
   logic [CW-1:0]       r_exact;
   logic [CW-1:0]       r_partial;
   logic [CW-1:0]       r_acc;
   logic [COLOR_BITS:0] r_c;
   logic                r_sv;
   logic                r_win;
   logic                r_lose;
   logic                r_armed;

   logic                  w_last;
   logic                  w_cap;
   logic                  w_scan_end;
   logic                  w_win;
   logic                  w_lose;
   logic [COLOR_BITS-1:0] w_col;
   logic [CW-1:0]         w_nc;
   logic [CW-1:0]         w_ng;
   logic [CW-1:0]         w_min;
   logic [CW-1:0]         w_ex;
   logic [GW-1:0]         w_gc_inc;

   assign w_last     = (r_idx == I_LAST);
   assign w_cap      = load & r_armed;
   assign w_scan_end = (r_c == C_END);
   assign w_col      = r_c[COLOR_BITS-1:0];
   assign w_gc_inc   = r_gc + GW'(1);
   assign w_win      = (w_ex == C_FULL);
   assign w_lose     = (w_gc_inc == G_MAX);
   assign w_min      = (w_nc < w_ng) ? w_nc : w_ng;

   // Per-colour occurrence counts for the colour under scan, plus exact hits
   always_comb begin
      w_nc = '0;
      w_ng = '0;
      w_ex = '0;
      for (int i = 0; i < PEGS; i++) begin
         if (r_code[i] == w_col)    w_nc = w_nc + CW'(1);
         if (r_guess[i] == w_col)   w_ng = w_ng + CW'(1);
         if (r_code[i] == r_guess[i]) w_ex = w_ex + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_LOAD;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (new_game) begin
         w_next = S_LOAD;
      end else begin
         case (r_state)
            S_LOAD:       if (w_cap) w_next = S_LOAD_WAIT;
            S_LOAD_WAIT:  if (!load) w_next = w_last ? S_GUESS : S_LOAD;
            S_GUESS:      if (w_cap) w_next = S_GUESS_WAIT;
            S_GUESS_WAIT: if (!load) w_next = w_last ? S_SCORE : S_GUESS;
            S_SCORE: begin
               if (w_scan_end) begin
                  if (w_win || w_lose) w_next = S_DONE;
                  else                 w_next = S_GUESS;
               end
            end
            S_DONE:  w_next = S_DONE;
            default: w_next = S_LOAD;
         endcase
      end
   end

   always_comb begin
      phase = 2'd0;
      case (r_state)
         S_GUESS, S_GUESS_WAIT: phase = 2'd1;
         S_SCORE:               phase = 2'd2;
         S_DONE:                phase = 2'd3;
         default:               phase = 2'd0;
      endcase
   end

   assign peg_index     = r_idx;
   assign guess_count   = r_gc;
   assign exact_count   = r_exact;
   assign partial_count = r_partial;
   assign score_valid   = r_sv;
   assign win           = r_win;
   assign lose          = r_lose;

   // A press only counts once load has been seen low since the last new_game
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         r_armed <= 1'b0;
      else if (new_game) r_armed <= 1'b0;
      else if (!load)    r_armed <= 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_code    <= '0;
         r_guess   <= '0;
         r_idx     <= '0;
         r_gc      <= '0;
         r_exact   <= '0;
         r_partial <= '0;
         r_acc     <= '0;
         r_c       <= '0;
         r_sv      <= 1'b0;
         r_win     <= 1'b0;
         r_lose    <= 1'b0;
      end else if (new_game) begin
         r_code    <= '0;
         r_guess   <= '0;
         r_idx     <= '0;
         r_gc      <= '0;
         r_exact   <= '0;
         r_partial <= '0;
         r_acc     <= '0;
         r_c       <= '0;
         r_sv      <= 1'b0;
         r_win     <= 1'b0;
         r_lose    <= 1'b0;
      end else begin
         r_sv <= 1'b0;
         case (r_state)
            S_LOAD: if (w_cap) r_code[r_idx] <= peg_in;
            S_LOAD_WAIT: begin
               if (!load) r_idx <= w_last ? '0 : r_idx + IW'(1);
            end
            S_GUESS: if (w_cap) r_guess[r_idx] <= peg_in;
            S_GUESS_WAIT: begin
               if (!load) begin
                  r_idx <= w_last ? '0 : r_idx + IW'(1);
                  r_c   <= '0;
                  r_acc <= '0;
               end
            end
            S_SCORE: begin
               if (!w_scan_end) begin
                  r_acc <= r_acc + w_min;
                  r_c   <= r_c + (COLOR_BITS + 1)'(1);
               end else begin
                  r_exact   <= w_ex;
                  r_partial <= r_acc - w_ex;
                  r_gc      <= w_gc_inc;
                  r_sv      <= 1'b1;
                  r_win     <= w_win;
                  r_lose    <= !w_win && w_lose;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mastermind_engine.sv
// Randomised bench for mastermind_engine against a pairing-based scoring model.
// Covers directed scoring cases, long presses, loss/win limits, reset and new_game.
module tb_mastermind_engine;

   localparam int PEGS = 4;
   localparam int CB   = 3;
   localparam int MAXG = 8;
   localparam int NC   = 1 << CB;
   localparam int CW   = $clog2(PEGS + 1);
   localparam int GW   = $clog2(MAXG + 1);
   localparam int IW   = $clog2(PEGS);

   logic          clk;
   logic          reset;
   logic          load;
   logic [CB-1:0] peg_in;
   logic          new_game;
   logic [1:0]    phase;
   logic [IW-1:0] peg_index;
   logic [GW-1:0] guess_count;
   logic [CW-1:0] exact_count;
   logic [CW-1:0] partial_count;
   logic          score_valid;
   logic          win;
   logic          lose;

   mastermind_engine #(
      .PEGS(PEGS), .COLOR_BITS(CB), .MAX_GUESSES(MAXG)
   ) dut (
      .clk(clk), .reset(reset), .load(load), .peg_in(peg_in),
      .new_game(new_game), .phase(phase), .peg_index(peg_index),
      .guess_count(guess_count), .exact_count(exact_count),
      .partial_count(partial_count), .score_valid(score_valid),
      .win(win), .lose(lose)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int m_code[PEGS];
   int m_gc  = 0;
   bit m_win = 0;
   bit m_lose = 0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Classic pairing: exact hits first, then each remaining guess peg
   // claims one unclaimed code peg of the same colour.
   function automatic void mm_score(input int c[PEGS], input int g[PEGS],
                                    output int ex, output int pa);
      bit cu[PEGS];
      bit gu[PEGS];
      bit found;
      ex = 0;
      pa = 0;
      for (int i = 0; i < PEGS; i++) begin
         cu[i] = (c[i] == g[i]);
         gu[i] = cu[i];
         if (cu[i]) ex++;
      end
      for (int i = 0; i < PEGS; i++) begin
         found = 0;
         if (!gu[i]) begin
            for (int j = 0; j < PEGS; j++) begin
               if (!found && !cu[j] && c[j] == g[i]) begin
                  cu[j] = 1;
                  found = 1;
                  pa++;
               end
            end
         end
      end
   endfunction

   task automatic press(input int p, input int hold, input bit scr);
      @(negedge clk);
      peg_in = CB'(p);
      load   = 1'b1;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         if (scr) peg_in = CB'(p + 1 + $urandom_range(NC - 2));
      end
      load = 1'b0;
      @(negedge clk);
   endtask

   task automatic ngame();
      @(negedge clk);
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      m_gc = 0; m_win = 0; m_lose = 0;
      chk("ng_phase", phase, 0);
      chk("ng_gc", guess_count, 0);
      chk("ng_win", win, 0);
      chk("ng_lose", lose, 0);
      chk("ng_exact", exact_count, 0);
   endtask

   task automatic enter_code(input int c[PEGS], input int hold, input bit scr);
      for (int i = 0; i < PEGS; i++) begin
         press(c[i], hold, scr);
         chk("code_idx", peg_index, (i + 1) % PEGS);
      end
      m_code = c;
      chk("code_phase", phase, 1);
   endtask

   task automatic do_guess(input int g[PEGS], input int hold, input bit scr);
      int ex, pa, k;
      for (int i = 0; i < PEGS; i++) begin
         press(g[i], hold, scr);
         if (i < PEGS - 1) chk("guess_idx", peg_index, i + 1);
      end
      chk("score_phase", phase, 2);
      mm_score(m_code, g, ex, pa);
      m_gc++;
      m_win  = (ex == PEGS);
      m_lose = !m_win && (m_gc == MAXG);
      k = 0;
      while (!score_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("latency", k, NC + 1);
      chk("exact", exact_count, ex);
      chk("partial", partial_count, pa);
      chk("gcount", guess_count, m_gc);
      chk("win", win, int'(m_win));
      chk("lose", lose, int'(m_lose));
      chk("phase_after", phase, (m_win || m_lose) ? 3 : 1);
      @(negedge clk);
      chk("sv_pulse", score_valid, 0);
   endtask

   task automatic rnd_code(output int c[PEGS]);
      for (int i = 0; i < PEGS; i++) c[i] = $urandom_range(NC - 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int c[PEGS];
      int g[PEGS];
      int n;
      reset = 1'b1; load = 1'b0; peg_in = '0; new_game = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_phase", phase, 0);
      chk("rst_idx", peg_index, 0);
      chk("rst_gc", guess_count, 0);
      chk("rst_exact", exact_count, 0);
      chk("rst_partial", partial_count, 0);
      chk("rst_sv", score_valid, 0);
      chk("rst_win", win, 0);
      chk("rst_lose", lose, 0);
      reset = 1'b0;
      @(negedge clk);

      c = '{1, 2, 3, 4};
      enter_code(c, 1, 0);
      g = '{1, 2, 3, 4};
      do_guess(g, 1, 0);

      ngame();
      enter_code(c, 1, 0);
      g = '{4, 3, 2, 1};
      do_guess(g, 2, 0);

      ngame();
      c = '{1, 1, 2, 2};
      enter_code(c, 1, 0);
      g = '{1, 2, 1, 5};
      do_guess(g, 1, 0);

      ngame();
      c = '{7, 7, 7, 7};
      enter_code(c, 1, 0);
      g = '{7, 0, 0, 0};
      do_guess(g, 1, 0);

      // eight misses end in a loss
      ngame();
      rnd_code(c);
      enter_code(c, 1, 0);
      for (int r = 0; r < MAXG; r++) begin
         rnd_code(g);
         g[0] = (c[0] + 1) % NC;
         do_guess(g, 1, 0);
      end
      // full match on the last allowed guess wins
      ngame();
      rnd_code(c);
      enter_code(c, 1, 0);
      for (int r = 0; r < MAXG - 1; r++) begin
         rnd_code(g);
         g[1] = (c[1] + 3) % NC;
         do_guess(g, 1, 0);
      end
      do_guess(c, 1, 0);

      // long presses with peg_in changing while held
      ngame();
      rnd_code(c);
      enter_code(c, 50, 1);
      rnd_code(g);
      do_guess(g, 50, 1);

      // new_game mid-score suppresses the pending result
      ngame();
      rnd_code(c);
      enter_code(c, 1, 0);
      rnd_code(g);
      for (int i = 0; i < PEGS; i++) press(g[i], 1, 0);
      repeat (3) @(negedge clk);
      ngame();
      n = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (score_valid) n++;
      end
      chk("ng_score_sv", n, 0);
      chk("ng_score_phase", phase, 0);

      // asynchronous reset in the middle of scoring
      rnd_code(c);
      enter_code(c, 1, 0);
      g = c;
      for (int i = 0; i < PEGS; i++) press(g[i], 1, 0);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_phase", phase, 0);
      chk("arst_idx", peg_index, 0);
      chk("arst_gc", guess_count, 0);
      chk("arst_exact", exact_count, 0);
      chk("arst_partial", partial_count, 0);
      chk("arst_sv", score_valid, 0);
      chk("arst_win", win, 0);
      chk("arst_lose", lose, 0);
      @(negedge clk);
      reset = 1'b0;
      m_gc = 0; m_win = 0; m_lose = 0;

      // new_game in DONE with load still pressed must not capture
      c = '{3, 0, 6, 2};
      enter_code(c, 1, 0);
      do_guess(c, 1, 0);
      @(negedge clk);
      load = 1'b1;
      peg_in = 3'd5;
      ngame();
      repeat (5) @(negedge clk);
      chk("held_idx", peg_index, 0);
      load = 1'b0;
      repeat (2) @(negedge clk);
      chk("held_nocap_idx", peg_index, 0);
      chk("held_phase", phase, 0);
      c = '{5, 5, 1, 0};
      enter_code(c, 1, 0);
      g = '{5, 1, 5, 5};
      do_guess(g, 1, 0);

      // random games
      for (int gm = 0; gm < 6; gm++) begin
         ngame();
         rnd_code(c);
         enter_code(c, $urandom_range(1, 3), 0);
         while (!m_win && !m_lose) begin
            if ($urandom_range(3) == 0) g = c;
            else rnd_code(g);
            do_guess(g, $urandom_range(1, 3), $urandom_range(1));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
